// File: rtl/pcileech_ft601_dev_emu.sv
// rtl/pcileech_ft601_dev_emu.sv - FT601 245 synchronous FIFO chip-side emulator
//
// Stands in for the physical FT601: host words are buffered in an RX FIFO and
// presented on the bus when the controller reads; controller writes are
// captured into a TX FIFO that the host drains through a valid/ready stream.
//
// Optional feature macro: FT601_EMU_THROTTLE_EN (LFSR-driven flag throttling).
//
// Ports:
//   clk, rst                      bus clock, synchronous active-high reset
//   ft601_rst_n                   controller chip reset (active low, flushes)
//   ft601_rd_n/oe_n/wr_n/siwu_n   controller strobes
//   ft601_rxf_n, ft601_txe_n      registered occupancy flags to controller
//   ft601_data_i/be_i             controller-driven bus data
//   ft601_data_o/be_o/data_oe     emulator-driven bus data and its enable
//   host_in_*                     host-to-FPGA word stream (into RX FIFO)
//   host_out_*                    FPGA-to-host word stream (out of TX FIFO)
//   err_proto/underrun/overrun    sticky error flags, cleared by rst only

module pcileech_ft601_dev_emu #(
  parameter int          PARAM_DEPTH_LOG2 = 9,
  parameter int          PARAM_TXE_MARGIN = 4,
  parameter logic [15:0] PARAM_LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ft601_rst_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_oe_n,
  input  logic        ft601_wr_n,
  input  logic        ft601_siwu_n,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic [31:0] ft601_data_i,
  input  logic [3:0]  ft601_be_i,
  output logic [31:0] ft601_data_o,
  output logic [3:0]  ft601_be_o,
  output logic        ft601_data_oe,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  input  logic [31:0] host_in_data,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  output logic [31:0] host_out_data,
  output logic [3:0]  host_out_be,
  output logic        err_proto,
  output logic        err_underrun,
  output logic        err_overrun
);

  localparam int DEPTH = 1 << PARAM_DEPTH_LOG2;
  localparam int PW    = PARAM_DEPTH_LOG2 + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t FULL_LEVEL = ptr_t'(DEPTH);
  localparam ptr_t TXE_LEVEL  = ptr_t'(DEPTH - PARAM_TXE_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ARM,
    ST_RD,
    ST_WR
  } state_t;

  logic flush;
  assign flush = rst | ~ft601_rst_n;

  // ---------------------------------------------------------------------------
  // Optional flag throttle
  // ---------------------------------------------------------------------------
  logic throttle;

`ifdef FT601_EMU_THROTTLE_EN
  logic [15:0] lfsr;

  // Galois right-shift form, taps 16,14,13,11 -> mask 16'hB400.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= PARAM_LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign throttle = (lfsr[1:0] == 2'b00);
`else
  assign throttle = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // RX FIFO (host -> FPGA), first-word-fall-through onto the bus
  // ---------------------------------------------------------------------------
  logic [31:0] rx_mem [DEPTH];
  ptr_t        rx_wp, rx_rp, rx_count, rx_count_nxt;
  logic        rx_empty, rx_push, rx_pop;
  logic        host_in_ready_q;

  assign rx_count = rx_wp - rx_rp;
  assign rx_empty = (rx_wp == rx_rp);

  // The registered ready already reflects post-cycle occupancy, so a push
  // accepted here can never land on a full FIFO.
  assign rx_push = host_in_valid & host_in_ready_q & ~flush;
  assign rx_pop  = ~ft601_rd_n & ~ft601_oe_n & ~rx_empty & ~flush;

  assign rx_count_nxt = rx_count + ptr_t'(rx_push) - ptr_t'(rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wp[PW-2:0]] <= host_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + ptr_t'(1);
      if (rx_pop)  rx_rp <= rx_rp + ptr_t'(1);
    end
  end

  assign ft601_data_oe = ~ft601_oe_n & ~flush;
  assign ft601_data_o  = flush    ? 32'h0000_0000 :
                         rx_empty ? 32'hFFFF_FFFF : rx_mem[rx_rp[PW-2:0]];
  assign ft601_be_o    = (flush | rx_empty) ? 4'h0 : 4'hF;

  // ---------------------------------------------------------------------------
  // TX FIFO (FPGA -> host), entries are {be, data}
  // ---------------------------------------------------------------------------
  logic [35:0] tx_mem [DEPTH];
  ptr_t        tx_wp, tx_rp, tx_count, tx_count_nxt;
  logic        tx_empty, tx_full, tx_wr, tx_push, tx_pop;

  assign tx_count = tx_wp - tx_rp;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_count == FULL_LEVEL);

  assign host_out_valid = ~tx_empty & ~flush;
  assign host_out_data  = tx_mem[tx_rp[PW-2:0]][31:0];
  assign host_out_be    = tx_mem[tx_rp[PW-2:0]][35:32];

  assign tx_wr   = ~ft601_wr_n & ft601_oe_n & ~flush;
  assign tx_pop  = host_out_valid & host_out_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can proceed.
  assign tx_push = tx_wr & (~tx_full | tx_pop);

  assign tx_count_nxt = tx_count + ptr_t'(tx_push) - ptr_t'(tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wp[PW-2:0]] <= {ft601_be_i, ft601_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + ptr_t'(1);
      if (tx_pop)  tx_rp <= tx_rp + ptr_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered flags: occupancy after this cycle's push/pop
  // ---------------------------------------------------------------------------
  logic rxf_n_q, txe_n_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      rxf_n_q         <= 1'b1;
      txe_n_q         <= 1'b1;
      host_in_ready_q <= 1'b0;
    end else begin
      rxf_n_q         <= (rx_count_nxt == '0) | throttle;
      txe_n_q         <= (tx_count_nxt >= TXE_LEVEL) | throttle;
      host_in_ready_q <= (rx_count_nxt != FULL_LEVEL);
    end
  end

  assign ft601_rxf_n   = rxf_n_q;
  assign ft601_txe_n   = txe_n_q;
  assign host_in_ready = host_in_ready_q;

  // ---------------------------------------------------------------------------
  // Data-path error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else if (!flush) begin
      if (!ft601_rd_n && rx_empty)      err_underrun <= 1'b1;
      if (tx_wr && tx_full && !tx_pop)  err_overrun  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus protocol checker FSM (observes strobes, never gates data)
  // ---------------------------------------------------------------------------
  state_t state;
  logic   viol;

  assign viol = ~ft601_siwu_n
              | (~ft601_wr_n & ~ft601_oe_n)
              | ((state == ST_WR) & ~ft601_oe_n)
              | ((state == ST_IDLE) & ~ft601_rd_n);

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= ST_IDLE;
      if (rst) err_proto <= 1'b0;
    end else if (viol) begin
      state     <= ST_IDLE;
      err_proto <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ft601_oe_n && ft601_rd_n)      state <= ST_RD_ARM;
          else if (!ft601_wr_n && ft601_oe_n) state <= ST_WR;
        end
        ST_RD_ARM: begin
          if (ft601_oe_n)       state <= ST_IDLE;
          else if (!ft601_rd_n) state <= ST_RD;
        end
        ST_RD: begin
          if (ft601_oe_n)      state <= ST_IDLE;
          else if (ft601_rd_n) state <= ST_RD_ARM;
        end
        ST_WR: begin
          if (ft601_wr_n) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_ft601_dev_emu.sv
// tb/tb_pcileech_ft601_dev_emu.sv - self-checking bench for pcileech_ft601_dev_emu

module tb_pcileech_ft601_dev_emu;

  logic        clk = 1'b0;
  logic        rst, ft601_rst_n, ft601_rd_n, ft601_oe_n, ft601_wr_n, ft601_siwu_n;
  logic        ft601_rxf_n, ft601_txe_n, ft601_data_oe;
  logic [31:0] ft601_data_i, ft601_data_o;
  logic [3:0]  ft601_be_i, ft601_be_o;
  logic        host_in_valid, host_in_ready;
  logic [31:0] host_in_data;
  logic        host_out_valid, host_out_ready;
  logic [31:0] host_out_data;
  logic [3:0]  host_out_be;
  logic        err_proto, err_underrun, err_overrun;

  always #5 clk = ~clk;

  pcileech_ft601_dev_emu dut (
    .clk(clk), .rst(rst), .ft601_rst_n(ft601_rst_n),
    .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n), .ft601_wr_n(ft601_wr_n),
    .ft601_siwu_n(ft601_siwu_n), .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .ft601_data_i(ft601_data_i), .ft601_be_i(ft601_be_i),
    .ft601_data_o(ft601_data_o), .ft601_be_o(ft601_be_o), .ft601_data_oe(ft601_data_oe),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .host_out_data(host_out_data), .host_out_be(host_out_be),
    .err_proto(err_proto), .err_underrun(err_underrun), .err_overrun(err_overrun)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain queues plus the flag values they imply.
  logic [31:0] rx_q[$];
  logic [35:0] tx_q[$];
  logic        m_rxf = 1'b1, m_txe = 1'b1, m_rdy = 1'b0;

  // One bus clock: check combinational outputs, advance the model, clock,
  // then check the registered flags.
  task automatic cycle();
    logic        fl, txp, rxp, can;
    logic [31:0] exp_d;
    logic [3:0]  exp_b;
    logic        exp_v;
    #1;
    fl = rst || !ft601_rst_n;
    tests++;
    if (ft601_data_oe !== (!ft601_oe_n && !fl)) begin
      fails++; $display("FAIL data_oe: got %b want %b", ft601_data_oe, !ft601_oe_n && !fl);
    end
    if (fl) begin exp_d = 32'h0; exp_b = 4'h0; end
    else if (rx_q.size() == 0) begin exp_d = 32'hFFFFFFFF; exp_b = 4'h0; end
    else begin exp_d = rx_q[0]; exp_b = 4'hF; end
    tests++;
    if (ft601_data_o !== exp_d || ft601_be_o !== exp_b) begin
      fails++; $display("FAIL bus_data: got %h/%h want %h/%h", ft601_data_o, ft601_be_o, exp_d, exp_b);
    end
    exp_v = !fl && (tx_q.size() > 0);
    tests++;
    if (host_out_valid !== exp_v) begin
      fails++; $display("FAIL host_out_valid: got %b want %b", host_out_valid, exp_v);
    end
    if (exp_v) begin
      tests++;
      if ({host_out_be, host_out_data} !== tx_q[0]) begin
        fails++; $display("FAIL host_out_word: got %h want %h", {host_out_be, host_out_data}, tx_q[0]);
      end
    end
    if (fl) begin
      rx_q.delete();
      tx_q.delete();
    end else begin
      txp = host_out_ready && (tx_q.size() > 0);
      can = !ft601_wr_n && ft601_oe_n && ((tx_q.size() < 512) || txp);
      if (txp) void'(tx_q.pop_front());
      if (can) tx_q.push_back({ft601_be_i, ft601_data_i});
      rxp = !ft601_rd_n && !ft601_oe_n && (rx_q.size() > 0);
      if (rxp) void'(rx_q.pop_front());
      if (host_in_valid && m_rdy) rx_q.push_back(host_in_data);
    end
    m_rdy = !fl && (rx_q.size() < 512);
    m_rxf = fl || (rx_q.size() == 0);
    m_txe = fl || ((512 - tx_q.size()) <= 4);
    @(posedge clk);
    #1;
    tests++;
    if (ft601_rxf_n !== m_rxf || ft601_txe_n !== m_txe || host_in_ready !== m_rdy) begin
      fails++;
      $display("FAIL flags: got rxf_n=%b txe_n=%b rdy=%b want %b %b %b",
               ft601_rxf_n, ft601_txe_n, host_in_ready, m_rxf, m_txe, m_rdy);
    end
  endtask

  task automatic read_words(input int n);
    ft601_oe_n = 1'b0; ft601_rd_n = 1'b1; cycle();
    for (int i = 0; i < n; i++) begin
      ft601_rd_n = (rx_q.size() > 0) ? 1'b0 : 1'b1;
      cycle();
    end
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    tests++;
    if (ft601_rxf_n !== 1'b1 || ft601_txe_n !== 1'b1 || ft601_data_oe !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got %b %b %b want 1 1 0", ft601_rxf_n, ft601_txe_n, ft601_data_oe);
    end
    tests++;
    if ({err_proto, err_underrun, err_overrun} !== 3'b000) begin
      fails++; $display("FAIL reset_errs: got %b want 000", {err_proto, err_underrun, err_overrun});
    end
    rst = 1'b0;
    cycle();
    tests++;
    if (ft601_txe_n !== 1'b0 || ft601_rxf_n !== 1'b1) begin
      fails++; $display("FAIL post_reset: got txe_n=%b rxf_n=%b want 0 1", ft601_txe_n, ft601_rxf_n);
    end
  endtask

  task automatic test_rx_read();
    logic [31:0] exp [3];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h33333333;
    host_in_valid = 1'b1;
    host_in_data = exp[0]; cycle();
    tests++;
    if (ft601_rxf_n !== 1'b0) begin
      fails++; $display("FAIL rxf_after_push: got %b want 0", ft601_rxf_n);
    end
    host_in_data = exp[1]; cycle();
    host_in_data = exp[2]; cycle();
    host_in_valid = 1'b0;
    ft601_oe_n = 1'b0; cycle();
    ft601_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (ft601_data_o !== exp[i]) begin
        fails++; $display("FAIL rx_read_%0d: got %h want %h", i, ft601_data_o, exp[i]);
      end
      cycle();
    end
    tests++;
    if (ft601_rxf_n !== 1'b1) begin
      fails++; $display("FAIL rxf_after_drain: got %b want 1", ft601_rxf_n);
    end
    ft601_rd_n = 1'b1; cycle();
    ft601_oe_n = 1'b1; cycle();
    tests++;
    if (err_underrun !== 1'b0) begin
      fails++; $display("FAIL rx_underrun: got %b want 0", err_underrun);
    end
  endtask

  task automatic test_tx_burst();
    ft601_be_i = 4'hF; ft601_wr_n = 1'b0;
    for (int i = 0; i < 513; i++) begin
      ft601_data_i = i;
      cycle();
      if (i == 506) begin
        tests++;
        if (ft601_txe_n !== 1'b0) begin fails++; $display("FAIL txe_at_507: got %b want 0", ft601_txe_n); end
      end
      if (i == 507) begin
        tests++;
        if (ft601_txe_n !== 1'b1) begin fails++; $display("FAIL txe_at_508: got %b want 1", ft601_txe_n); end
      end
      if (i == 511) begin
        tests++;
        if (err_overrun !== 1'b0) begin fails++; $display("FAIL overrun_early: got %b want 0", err_overrun); end
      end
    end
    tests++;
    if (err_overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_513: got %b want 1", err_overrun);
    end
    ft601_wr_n = 1'b1; cycle();
  endtask

  task automatic test_tx_drain();
    host_out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      #1;
      tests++;
      if (host_out_data !== 32'(i) || host_out_be !== 4'hF) begin
        fails++; $display("FAIL drain_%0d: got %h/%h want %h/f", i, host_out_data, host_out_be, i);
      end
      cycle();
    end
    host_out_ready = 1'b0;
    tests++;
    if (host_out_valid !== 1'b0 || ft601_txe_n !== 1'b0) begin
      fails++; $display("FAIL drain_end: got valid=%b txe_n=%b want 0 0", host_out_valid, ft601_txe_n);
    end
  endtask

  task automatic test_random();
    for (int op = 0; op < 60; op++) begin
      int k;
      k = 1 + int'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin
          repeat (k) begin
            host_in_valid = $urandom_range(0, 1); host_in_data = $urandom;
            host_out_ready = $urandom_range(0, 1);
            cycle();
          end
        end
        1: begin
          host_in_valid = $urandom_range(0, 1); host_in_data = $urandom;
          host_out_ready = $urandom_range(0, 1);
          ft601_oe_n = 1'b0; cycle();
          repeat (k) begin
            host_in_valid = $urandom_range(0, 1); host_in_data = $urandom;
            host_out_ready = $urandom_range(0, 1);
            ft601_rd_n = (rx_q.size() > 0 && $urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            cycle();
          end
          ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; cycle();
        end
        default: begin
          repeat (k) begin
            host_in_valid = $urandom_range(0, 1); host_in_data = $urandom;
            host_out_ready = $urandom_range(0, 1);
            ft601_wr_n = $urandom_range(0, 3) == 0 ? 1'b1 : 1'b0;
            ft601_data_i = $urandom; ft601_be_i = 4'($urandom);
            cycle();
          end
          ft601_wr_n = 1'b1; cycle();
        end
      endcase
    end
    host_in_valid = 1'b0;
    host_out_ready = 1'b1;
    read_words(rx_q.size());
    while (tx_q.size() > 0) cycle();
    host_out_ready = 1'b0;
    cycle();
    tests++;
    if (err_proto !== 1'b0 || err_underrun !== 1'b0) begin
      fails++; $display("FAIL random_errs: got proto=%b underrun=%b want 0 0", err_proto, err_underrun);
    end
  endtask

  task automatic test_proto();
    host_in_valid = 1'b1; host_in_data = 32'hA5A5_5A5A; cycle();
    host_in_valid = 1'b0;
    ft601_rd_n = 1'b0; ft601_oe_n = 1'b1; cycle();
    tests++;
    if (err_proto !== 1'b1 || ft601_rxf_n !== 1'b0 || ft601_data_o !== 32'hA5A5_5A5A) begin
      fails++; $display("FAIL proto_rd: got err=%b rxf_n=%b d=%h want 1 0 a5a55a5a", err_proto, ft601_rxf_n, ft601_data_o);
    end
    ft601_rd_n = 1'b1; ft601_wr_n = 1'b0; ft601_oe_n = 1'b0;
    ft601_data_i = 32'h0BAD_0BAD; ft601_be_i = 4'hF; cycle();
    tests++;
    if (err_proto !== 1'b1 || host_out_valid !== 1'b0) begin
      fails++; $display("FAIL proto_wr: got err=%b valid=%b want 1 0", err_proto, host_out_valid);
    end
    ft601_wr_n = 1'b1; ft601_oe_n = 1'b1; cycle();
    read_words(1);
  endtask

  task automatic test_flush();
    logic [2:0] errs;
    host_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin host_in_data = $urandom; cycle(); end
    host_in_valid = 1'b0;
    ft601_oe_n = 1'b0; cycle();
    ft601_rd_n = 1'b0; cycle();
    errs = {err_proto, err_underrun, err_overrun};
    ft601_rst_n = 1'b0; cycle();
    ft601_rst_n = 1'b1; ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;
    tests++;
    if (ft601_rxf_n !== 1'b1 || {err_proto, err_underrun, err_overrun} !== errs) begin
      fails++; $display("FAIL flush: got rxf_n=%b errs=%b want 1 %b", ft601_rxf_n, {err_proto, err_underrun, err_overrun}, errs);
    end
    cycle();
    tests++;
    if (ft601_rxf_n !== 1'b1 || {err_proto, err_underrun, err_overrun} !== errs) begin
      fails++; $display("FAIL post_flush: got rxf_n=%b errs=%b want 1 %b", ft601_rxf_n, {err_proto, err_underrun, err_overrun}, errs);
    end
    host_in_valid = 1'b1; host_in_data = 32'hDEADBEEF; cycle();
    host_in_valid = 1'b0;
    ft601_oe_n = 1'b0; cycle();
    #1;
    tests++;
    if (ft601_data_o !== 32'hDEADBEEF || ft601_be_o !== 4'hF) begin
      fails++; $display("FAIL deadbeef: got %h/%h want deadbeef/f", ft601_data_o, ft601_be_o);
    end
    ft601_rd_n = 1'b0; cycle();
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; cycle();
    tests++;
    if (ft601_rxf_n !== 1'b1) begin
      fails++; $display("FAIL deadbeef_pop: got rxf_n=%b want 1", ft601_rxf_n);
    end
  endtask

  initial begin
    rst = 1'b1; ft601_rst_n = 1'b1;
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; ft601_wr_n = 1'b1; ft601_siwu_n = 1'b1;
    ft601_data_i = '0; ft601_be_i = '0;
    host_in_valid = 1'b0; host_in_data = '0; host_out_ready = 1'b0;
    test_reset();
    test_rx_read();
    test_tx_burst();
    test_tx_drain();
    test_random();
    test_proto();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
